cmd_seq_decode: RTL

- Consumer end of the 32-bit encoded memory-command stream produced by the cmd_encod_* generators (linear write/read, etc.).
- Buffers encoded words in a small FIFO, then expands each word into per-cycle PHY controls: address, bank, RCW, ODT, DQ/DQS, and buffer strobes.
- Expands pause words and the appended NOP cycle, and signals end of sequence.
- Sits between the command encoders and the PHY control sequencer.

---
 rtl/cmd_seq_pkg.sv | 77 +++++++
 rtl/cmd_seq_fifo.sv | 69 ++++++
 rtl/cmd_seq_decode.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cmd_seq_pkg.sv
// Shared definitions for the encoded memory-command word: field positions,
// RCW codes and the decoder state type. Encoders and decoder both use these.
package cmd_seq_pkg;

    // Bit positions inside the 32-bit encoded word
    localparam int unsigned CmdAddrMsb      = 31;
    localparam int unsigned CmdAddrLsb      = 17;
    localparam int unsigned CmdBankMsb      = 16;
    localparam int unsigned CmdBankLsb      = 14;
    localparam int unsigned CmdRcwMsb       = 13;
    localparam int unsigned CmdRcwLsb       = 11;
    localparam int unsigned CmdOdtBit       = 10;
    localparam int unsigned CmdCkeDisBit    = 9;
    localparam int unsigned CmdSelBit       = 8;
    localparam int unsigned CmdDqEnBit      = 7;
    localparam int unsigned CmdDqsEnBit     = 6;
    localparam int unsigned CmdDqsToggleBit = 5;
    localparam int unsigned CmdDciBit       = 4;
    localparam int unsigned CmdBufWrBit     = 3;
    localparam int unsigned CmdBufRdBit     = 2;
    localparam int unsigned CmdNopBit       = 1;

    // Pause-word field defaults (skip count and end-of-sequence flag live in addr)
    localparam int unsigned CmdPauseBitsDef = 10;
    localparam int unsigned CmdDoneBitDef   = 10;

    // RAS/CAS/WE in positive logic
    typedef enum logic [2:0] {
        RcwNop       = 3'd0,
        RcwRead      = 3'd2,
        RcwWrite     = 3'd3,
        RcwActivate  = 3'd4,
        RcwPrecharge = 3'd5
    } rcw_e;

    // Packed view of the encoded word, MSB first, matching the bit positions above
    typedef struct packed {
        logic [14:0] addr;
        logic [2:0]  bank;
        logic [2:0]  rcw;
        logic        odt;
        logic        cke_dis;
        logic        sel;
        logic        dq_en;
        logic        dqs_en;
        logic        dqs_toggle;
        logic        dci;
        logic        buf_wr;
        logic        buf_rd;
        logic        nop;
        logic        rsvd;
    } cmd_word_t;

    typedef enum logic [2:0] {
        StIdle,
        StExec,
        StNop,
        StPause,
        StDone,
        StUnder
    } seq_state_e;

    // A word with no RAS/CAS/WE activity is a pause word
    function automatic logic is_pause(input cmd_word_t w);
        return w.rcw == RcwNop;
    endfunction

    // Output image while starved: everything off except ODT and CKE disable
    function automatic cmd_word_t under_word(input cmd_word_t w);
        cmd_word_t r;
        r         = '0;
        r.odt     = w.odt;
        r.cke_dis = w.cke_dis;
        return r;
    endfunction

endpackage

// File: rtl/cmd_seq_fifo.sv
// Synchronous command FIFO with occupancy count, registered full flag and
// a strobe for a push that had to be dropped.
module cmd_seq_fifo #(
    parameter int unsigned Width     = 32,
    parameter int unsigned DepthBits = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic [Width-1:0]     wdata_i,
    input  logic                 pop_i,
    output logic [Width-1:0]     rdata_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic [DepthBits:0]   count_o,
    output logic                 overflow_o
);

    localparam int unsigned Depth = 1 << DepthBits;

    logic [Width-1:0]     mem_q [Depth];
    logic [DepthBits-1:0] wptr_q;
    logic [DepthBits-1:0] rptr_q;
    logic [DepthBits:0]   count_q;
    logic [DepthBits:0]   count_d;
    logic                 full_q;
    logic                 do_push;
    logic                 do_pop;

    assign empty_o    = (count_q == '0);
    assign do_pop     = pop_i && !empty_o;
    // A push into a full FIFO still fits when the head leaves in the same cycle
    assign do_push    = push_i && (!full_q || do_pop);
    assign overflow_o = push_i && !do_push;
    assign rdata_o    = mem_q[rptr_q];
    assign full_o     = full_q;
    assign count_o    = count_q;

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    // Pointers, count and full flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == (DepthBits + 1)'(Depth));
        end
    end

    // Storage array, no reset needed since reads are gated by count
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/cmd_seq_decode.sv
// Command sequence decoder: buffers encoded command words and expands each
// one into per-cycle PHY controls, including pause and NOP expansion.
module cmd_seq_decode
    import cmd_seq_pkg::*;
#(
    parameter int unsigned ADDRESS_NUMBER  = 15,
    parameter int unsigned CMD_PAUSE_BITS  = CmdPauseBitsDef,
    parameter int unsigned CMD_DONE_BIT    = CmdDoneBitDef,
    parameter int unsigned FIFO_DEPTH_BITS = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [31:0]               enc_cmd_i,
    input  logic                      enc_wr_i,
    output logic [ADDRESS_NUMBER-1:0] phy_addr_o,
    output logic [2:0]                phy_bank_o,
    output logic [2:0]                phy_rcw_o,
    output logic                      phy_odt_o,
    output logic                      phy_cke_dis_o,
    output logic                      phy_sel_o,
    output logic                      phy_dq_en_o,
    output logic                      phy_dqs_en_o,
    output logic                      phy_dqs_toggle_o,
    output logic                      phy_dci_o,
    output logic                      phy_buf_wr_o,
    output logic                      phy_buf_rd_o,
    output logic                      seq_busy_o,
    output logic                      seq_done_o,
    output logic                      fifo_full_o,
    output logic                      err_underrun_o,
    output logic                      err_overflow_o
);

    localparam logic [CMD_PAUSE_BITS-1:0] CntOne = CMD_PAUSE_BITS'(1);

    logic [31:0]               fifo_rdata;
    logic                      fifo_empty;
    logic                      fifo_overflow;
    logic [FIFO_DEPTH_BITS:0]  unused_fifo_count;
    logic                      pop;
    logic                      advance;

    cmd_word_t                 head_w;
    cmd_word_t                 out_q;
    seq_state_e                state_q;
    logic [CMD_PAUSE_BITS-1:0] cnt_q;
    logic                      seq_busy_q;
    logic                      seq_done_q;
    logic                      err_underrun_q;
    logic                      err_overflow_q;

    logic                      cur_pause;
    logic                      cur_nop_cmd;
    logic                      cur_done;
    logic [CMD_PAUSE_BITS-1:0] cur_skip;
    logic                      unused_rsvd;

    cmd_seq_fifo #(
        .Width     (32),
        .DepthBits (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (enc_wr_i),
        .wdata_i    (enc_cmd_i),
        .pop_i      (pop),
        .rdata_o    (fifo_rdata),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full_o),
        .count_o    (unused_fifo_count),
        .overflow_o (fifo_overflow)
    );

    assign head_w = cmd_word_t'(fifo_rdata);

    // Decode of the word currently on the outputs (valid in StExec/StPause)
    always_comb begin
        cur_pause   = is_pause(out_q);
        cur_nop_cmd = !cur_pause && out_q.nop;
        cur_skip    = out_q.addr[CMD_PAUSE_BITS-1:0];
        cur_done    = out_q.addr[CMD_DONE_BIT];
    end

    // Decide whether this cycle wants the next word from the FIFO
    always_comb begin
        advance = 1'b0;
        unique case (state_q)
            StIdle, StUnder, StNop: advance = 1'b1;
            StExec:  advance = !cur_nop_cmd && !(cur_pause && ((cur_skip != '0) || cur_done));
            StPause: advance = (cnt_q == CntOne) && !cur_done;
            default: advance = 1'b0;
        endcase
    end

    assign pop = advance && !fifo_empty;

    // Sequencer FSM with registered PHY outputs and sticky error flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            out_q          <= '0;
            cnt_q          <= '0;
            seq_busy_q     <= 1'b0;
            seq_done_q     <= 1'b0;
            err_underrun_q <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            seq_done_q <= 1'b0;
            if (fifo_overflow) err_overflow_q <= 1'b1;

            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        out_q      <= head_w;
                        seq_busy_q <= 1'b1;
                        state_q    <= StExec;
                    end
                end
                StExec: begin
                    if (cur_nop_cmd) begin
                        out_q.rcw <= RcwNop;
                        state_q   <= StNop;
                    end else if (cur_pause && (cur_skip != '0)) begin
                        cnt_q   <= cur_skip;
                        state_q <= StPause;
                    end else if (cur_pause && cur_done) begin
                        out_q      <= '0;
                        seq_busy_q <= 1'b0;
                        seq_done_q <= 1'b1;
                        state_q    <= StDone;
                    end else if (pop) begin
                        out_q <= head_w;
                    end else begin
                        out_q          <= under_word(out_q);
                        err_underrun_q <= 1'b1;
                        state_q        <= StUnder;
                    end
                end
                StNop: begin
                    if (pop) begin
                        out_q   <= head_w;
                        state_q <= StExec;
                    end else begin
                        out_q          <= under_word(out_q);
                        err_underrun_q <= 1'b1;
                        state_q        <= StUnder;
                    end
                end
                StPause: begin
                    if (cnt_q != CntOne) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (cur_done) begin
                        out_q      <= '0;
                        seq_busy_q <= 1'b0;
                        seq_done_q <= 1'b1;
                        state_q    <= StDone;
                    end else if (pop) begin
                        out_q   <= head_w;
                        state_q <= StExec;
                    end else begin
                        out_q          <= under_word(out_q);
                        err_underrun_q <= 1'b1;
                        state_q        <= StUnder;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                StUnder: begin
                    if (pop) begin
                        out_q   <= head_w;
                        state_q <= StExec;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign phy_addr_o       = out_q.addr[ADDRESS_NUMBER-1:0];
    assign phy_bank_o       = out_q.bank;
    assign phy_rcw_o        = out_q.rcw;
    assign phy_odt_o        = out_q.odt;
    assign phy_cke_dis_o    = out_q.cke_dis;
    assign phy_sel_o        = out_q.sel;
    assign phy_dq_en_o      = out_q.dq_en;
    assign phy_dqs_en_o     = out_q.dqs_en;
    assign phy_dqs_toggle_o = out_q.dqs_toggle;
    assign phy_dci_o        = out_q.dci;
    assign phy_buf_wr_o     = out_q.buf_wr;
    assign phy_buf_rd_o     = out_q.buf_rd;
    assign seq_busy_o       = seq_busy_q;
    assign seq_done_o       = seq_done_q;
    assign err_underrun_o   = err_underrun_q;
    assign err_overflow_o   = err_overflow_q;

    // The reserved bit is carried in the word image but never driven out
    assign unused_rsvd = out_q.rsvd;

endmodule
